// File: rtl/hlsm_pkg.sv
// -----------------------------------------------------------------------------
// hlsm_pkg
// Shared definitions for the operand dispatcher and the HLSM it feeds:
// default operand width, the six-operand tuple type and the dispatcher
// state encoding.
// -----------------------------------------------------------------------------
package hlsm_pkg;

    // Default operand/result width in bits (two's complement).
    localparam int W_DEFAULT = 16;

    // Operand tuple as it travels through the queue; field a sits in the MSBs
    // so the packed struct lines up with the flat in_ops bus.
    typedef struct packed {
        logic signed [W_DEFAULT-1:0] a;
        logic signed [W_DEFAULT-1:0] b;
        logic signed [W_DEFAULT-1:0] c;
        logic signed [W_DEFAULT-1:0] d;
        logic signed [W_DEFAULT-1:0] e;
        logic signed [W_DEFAULT-1:0] f;
    } op_tuple_t;

    // Dispatcher control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } disp_state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// -----------------------------------------------------------------------------
// dispatch_fifo
// Show-ahead operand queue: rd_data always presents the head entry. A push
// while full is dropped unless a pop happens in the same cycle, in which case
// both take effect and the occupancy stays at DEPTH.
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage write port.
    // NOTE: the array is deliberately not reset; the pointers and count alone
    // say which entries are valid, and leaving it out keeps it in plain RAM.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs as they stood before the edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_dispatcher.sv
// -----------------------------------------------------------------------------
// operand_dispatcher
// Queues six-operand tuples and hands them one at a time to a downstream
// HLSM: pops the head into the op_* registers, pulses Start for one cycle,
// then waits for Done and captures j_in/k_in into a one-entry result register.
// Only one HLSM operation is ever outstanding, so results leave in issue order.
// A new operation is launched only when the result register is free or is
// being drained in the same cycle.
//
// Build option: define DISPATCH_TIMEOUT_EN to abort an operation after TIMEOUT
// WAIT cycles without Done; the abort sets the sticky timeout_err flag, drops
// the operation without producing a result and returns to IDLE. Without the
// macro the dispatcher waits indefinitely and timeout_err is tied low.
// -----------------------------------------------------------------------------
module operand_dispatcher
    import hlsm_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [6*W-1:0] in_ops,
    output logic         Start,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] op_c,
    output logic [W-1:0] op_d,
    output logic [W-1:0] op_e,
    output logic [W-1:0] op_f,
    input  logic         Done,
    input  logic [W-1:0] j_in,
    input  logic [W-1:0] k_in,
    output logic         res_valid,
    output logic [W-1:0] res_j,
    output logic [W-1:0] res_k,
    input  logic         res_ready,
    output logic         busy,
    output logic         timeout_err
);

    disp_state_t    state;
    disp_state_t    state_next;
    logic [6*W-1:0] head_ops;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           launch;
    logic           capture;
    logic           expire;

    // ---------------------------------------------------------------------
    // Operand queue
    // ---------------------------------------------------------------------
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (6*W)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push    (push),
        .wr_data (in_ops),
        .pop     (launch),
        .rd_data (head_ops),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------------
    // Launch needs a queued tuple and a result slot that is empty or being
    // drained this cycle; capture only counts while actually waiting, so a
    // stray Done in IDLE or LAUNCH is ignored.
    assign launch  = (state == ST_IDLE) & ~fifo_empty & (~res_valid | res_ready);
    assign capture = (state == ST_WAIT) & Done;
    assign Start   = (state == ST_LAUNCH);
    assign busy    = (state != ST_IDLE);

`ifdef DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    // The WAIT cycle that completes the TIMEOUT-th cycle without Done aborts.
    assign expire = (state == ST_WAIT) & ~Done & (wait_cnt == CW'(TIMEOUT - 1));

    // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state decode for the IDLE -> LAUNCH -> WAIT -> IDLE loop.
    // NOTE: combinational logic uses blocking assignments and assigns its
    // output a default before any branch, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture || expire) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers: loaded from the queue head on the launch edge and
    // held untouched until the next launch, covering the whole Start..Done span.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_a <= '0;
            op_b <= '0;
            op_c <= '0;
            op_d <= '0;
            op_e <= '0;
            op_f <= '0;
        end else if (launch) begin
            op_a <= head_ops[6*W-1 -: W];
            op_b <= head_ops[5*W-1 -: W];
            op_c <= head_ops[4*W-1 -: W];
            op_d <= head_ops[3*W-1 -: W];
            op_e <= head_ops[2*W-1 -: W];
            op_f <= head_ops[1*W-1 -: W];
        end
    end

    // Result register: a capture takes priority over a drain in the same
    // cycle, so the new result stays visible rather than being lost.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            res_valid <= 1'b0;
            res_j     <= '0;
            res_k     <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_j     <= j_in;
            res_k     <= k_in;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_operand_dispatcher
// Directed bench for operand_dispatcher with default parameters
// (W=16, DEPTH=4, TIMEOUT=64). Steps through reset, a single operation,
// queue-full back-pressure with a blocked result, ordering of five queued
// operations, stray Done pulses, the WAIT behaviour with and without
// DISPATCH_TIMEOUT_EN, and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_operand_dispatcher;
    import hlsm_pkg::*;

    localparam int W = 16;

    logic         Clk;
    logic         Rst;
    logic         in_valid;
    logic         in_ready;
    logic [6*W-1:0] in_ops;
    logic         Start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] op_c;
    logic [W-1:0] op_d;
    logic [W-1:0] op_e;
    logic [W-1:0] op_f;
    logic         Done;
    logic [W-1:0] j_in;
    logic [W-1:0] k_in;
    logic         res_valid;
    logic [W-1:0] res_j;
    logic [W-1:0] res_k;
    logic         res_ready;
    logic         busy;
    logic         timeout_err;

    int passed = 0;
    int total  = 0;
    int start_count = 0;

    op_tuple_t tq [5];
    logic [W-1:0] jt [5];
    logic [W-1:0] kt [5];
    op_tuple_t t0;
    op_tuple_t t6;
    op_tuple_t t7;

    operand_dispatcher dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ops      (in_ops),
        .Start       (Start),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_c        (op_c),
        .op_d        (op_d),
        .op_e        (op_e),
        .op_f        (op_f),
        .Done        (Done),
        .j_in        (j_in),
        .k_in        (k_in),
        .res_valid   (res_valid),
        .res_j       (res_j),
        .res_k       (res_k),
        .res_ready   (res_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count Start pulses, sampled mid-cycle.
    always @(negedge Clk) begin
        if (Start === 1'b1) begin
            start_count <= start_count + 1;
        end
    end

    // Hard stop in case a step never returns.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present a tuple and hold it until it is accepted (bounded).
    task automatic push(input op_tuple_t t);
        int n = 0;
        in_valid = 1'b1;
        in_ops   = t;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("push_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Advance until Start is seen (bounded).
    task automatic wait_start(input string tag);
        int n = 0;
        while (Start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(Start), 32'd1);
    endtask

    // One-cycle Done pulse carrying the given results.
    task automatic pulse_done(input logic [W-1:0] j, input logic [W-1:0] k);
        Done = 1'b1;
        j_in = j;
        k_in = k;
        tick();
        Done = 1'b0;
    endtask

    initial begin
        Rst       = 1'b1;
        in_valid  = 1'b0;
        in_ops    = '0;
        Done      = 1'b0;
        j_in      = '0;
        k_in      = '0;
        res_ready = 1'b0;

        t0    = '{16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7};
        tq[0] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6};
        tq[1] = '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd50, 16'sd60};
        tq[2] = '{16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd500, 16'sd600};
        tq[3] = '{16'sd7, 16'sd8, 16'sd9, 16'sd10, 16'sd11, 16'sd12};
        tq[4] = '{16'sd9, 16'sd8, 16'sd7, 16'sd6, 16'sd5, 16'sd14};
        t6    = '{16'sd21, 16'sd22, 16'sd23, 16'sd24, 16'sd25, 16'sd26};
        t7    = '{16'sd31, 16'sd32, 16'sd33, 16'sd34, 16'sd35, 16'sd36};
        jt[0] = 16'd11;  kt[0] = 16'd111;
        jt[1] = 16'd22;  kt[1] = 16'd222;
        jt[2] = 16'd33;  kt[2] = 16'd333;
        jt[3] = 16'd44;  kt[3] = 16'd444;
        jt[4] = 16'd55;  kt[4] = 16'd555;

        // ---- Reset state ----
        tick();
        tick();
        Rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_start",     32'(Start),       32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_res_valid", 32'(res_valid),   32'd0);
        check("rst_res_j",     32'(res_j),       32'd0);
        check("rst_op_a",      32'(op_a),        32'd0);
        check("rst_timeout",   32'(timeout_err), 32'd0);

        // ---- Single operation {2,3,4,5,6,7}, Done 6 cycles after Start ----
        push(t0);
        wait_start("single_start");
        check("single_op_a", 32'(op_a), 32'd2);
        check("single_op_b", 32'(op_b), 32'd3);
        check("single_op_c", 32'(op_c), 32'd4);
        check("single_op_d", 32'(op_d), 32'd5);
        check("single_op_e", 32'(op_e), 32'd6);
        check("single_op_f", 32'(op_f), 32'd7);
        tick();
        check("single_start_one_cycle", 32'(Start), 32'd0);
        check("single_busy_wait",       32'(busy),  32'd1);
        repeat (5) tick();
        pulse_done(16'd50, 16'd42);
        check("single_res_valid", 32'(res_valid), 32'd1);
        check("single_res_j",     32'(res_j),     32'd50);
        check("single_res_k",     32'(res_k),     32'd42);
        check("single_idle",      32'(busy),      32'd0);
        check("single_one_start", 32'(start_count), 32'd1);

        // ---- Result held (res_ready=0), fill queue with 4, 5th held ----
        for (int i = 0; i < 4; i++) begin
            push(tq[i]);
        end
        check("full_in_ready",  32'(in_ready),    32'd0);
        check("blocked_busy",   32'(busy),        32'd0);
        check("blocked_rvalid", 32'(res_valid),   32'd1);
        in_valid = 1'b1;
        in_ops   = tq[4];
        tick();
        tick();
        check("fifth_held",      32'(in_ready),    32'd0);
        check("blocked_nostart", 32'(start_count), 32'd1);

        // Release the result: launch of the first queued tuple, slot drained.
        res_ready = 1'b1;
        tick();
        check("release_start",  32'(Start),     32'd1);
        check("release_op_a",   32'(op_a),      32'(tq[0].a));
        check("release_rvalid", 32'(res_valid), 32'd0);
        check("release_ready",  32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        check("fifth_taken_full", 32'(in_ready), 32'd0);
        check("launch_start_off", 32'(Start),    32'd0);

        // ---- Five operations complete in issue order ----
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_start("order_start");
                check("order_op_a", 32'(op_a), 32'(tq[i].a));
                check("order_op_f", 32'(op_f), 32'(tq[i].f));
                tick();
            end
            tick();
            // res_ready is high during this capture cycle; capture must win.
            pulse_done(jt[i], kt[i]);
            check("order_res_valid", 32'(res_valid), 32'd1);
            check("order_res_j",     32'(res_j),     32'(jt[i]));
            check("order_res_k",     32'(res_k),     32'(kt[i]));
        end
        tick();
        check("drain_rvalid",  32'(res_valid),   32'd0);
        check("drain_idle",    32'(busy),        32'd0);
        check("drain_ready",   32'(in_ready),    32'd1);
        check("drain_starts",  32'(start_count), 32'd6);

        // ---- Done while IDLE is ignored ----
        pulse_done(16'd99, 16'd99);
        check("idle_done_rvalid", 32'(res_valid), 32'd0);
        check("idle_done_res_j",  32'(res_j),     32'd55);

        // ---- Done while LAUNCH is ignored; second tuple queued behind ----
        push(t6);
        in_valid = 1'b1;
        in_ops   = t7;
        tick();
        in_valid = 1'b0;
        check("t6_start", 32'(Start), 32'd1);
        check("t6_op_a",  32'(op_a),  32'd21);
        pulse_done(16'd77, 16'd77);
        check("launch_done_rvalid", 32'(res_valid), 32'd0);
        check("launch_done_busy",   32'(busy),      32'd1);
        check("launch_done_start",  32'(Start),     32'd0);

`ifdef DISPATCH_TIMEOUT_EN
        // ---- No Done: abort on WAIT cycle 64, queued tuple launches next ----
        repeat (63) tick();
        check("to_before_err",  32'(timeout_err), 32'd0);
        check("to_before_busy", 32'(busy),        32'd1);
        tick();
        check("to_err_set",     32'(timeout_err), 32'd1);
        check("to_idle",        32'(busy),        32'd0);
        check("to_no_result",   32'(res_valid),   32'd0);
        tick();
        check("to_next_start",  32'(Start),       32'd1);
        check("to_next_op_a",   32'(op_a),        32'd31);
        check("to_err_sticky",  32'(timeout_err), 32'd1);
        tick();
        tick();
`else
        // ---- No Done: WAIT persists, no abort flag ----
        repeat (70) tick();
        check("nodone_busy",    32'(busy),        32'd1);
        check("nodone_timeout", 32'(timeout_err), 32'd0);
        check("nodone_rvalid",  32'(res_valid),   32'd0);
`endif

        // ---- Reset mid-WAIT, Done arriving 2 cycles later ----
        check("pre_rst_busy", 32'(busy), 32'd1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        tick();
        pulse_done(16'd123, 16'd45);
        check("mid_rst_rvalid",  32'(res_valid),   32'd0);
        check("mid_rst_busy",    32'(busy),        32'd0);
        check("mid_rst_empty",   32'(in_ready),    32'd1);
        check("mid_rst_op_a",    32'(op_a),        32'd0);
        check("mid_rst_res_j",   32'(res_j),       32'd0);
        check("mid_rst_timeout", 32'(timeout_err), 32'd0);
        repeat (3) tick();
        check("mid_rst_still_idle", 32'(busy), 32'd0);
`ifdef DISPATCH_TIMEOUT_EN
        check("final_starts", 32'(start_count), 32'd8);
`else
        check("final_starts", 32'(start_count), 32'd7);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
